// File: rtl/mpram_banked_pkg.sv
// Shared types and width helpers for the banked multi-port RAM.
// Pipeline stages carry a fixed-width data field; ports narrower than MAX_DWIDTH zero-extend.
package mpram_pkg;

    localparam int unsigned MAX_DWIDTH = 64;

    function automatic int unsigned bank_bits(input int unsigned nbanks);
        return $clog2(nbanks);
    endfunction

    function automatic int unsigned row_bits(input int unsigned awidth, input int unsigned nbanks);
        return awidth - $clog2(nbanks);
    endfunction

    function automatic int unsigned port_idx_bits(input int unsigned nports);
        return (nports > 1) ? $clog2(nports) : 1;
    endfunction

    typedef struct packed {
        logic                  valid;
        logic [MAX_DWIDTH-1:0] data;
    } rd_tag_t;

endpackage

// File: rtl/mpram_banked_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts at a registered pointer
// which moves to one past the granted requester.
module rr_arbiter
    import mpram_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o
);

    localparam int unsigned PW = port_idx_bits(N);

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] gnt_idx;
    logic          found;
    int unsigned   idx;

    always_comb begin
        gnt_o   = '0;
        found   = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = (32'(ptr_q) + i) % N;
            if (!found && req_i[idx[PW-1:0]]) begin
                found                = 1'b1;
                gnt_o[idx[PW-1:0]]   = 1'b1;
                gnt_idx              = idx[PW-1:0];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mpram_banked.sv
// NPORTS-port RAM built from NBANKS low-order-interleaved single-port banks,
// one round-robin arbiter per bank and a 1- or 2-stage per-port read pipeline.
module mpram_banked
    import mpram_pkg::*;
#(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned AWIDTH = 8,
    parameter int unsigned NPORTS = 4,
    parameter int unsigned NBANKS = 4,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [NPORTS-1:0]        en_in,
    input  logic [NPORTS-1:0]        we_in,
    input  logic [NPORTS*AWIDTH-1:0] addr_in,
    input  logic [NPORTS*DWIDTH-1:0] d_in,
    output logic [NPORTS-1:0]        ready_out,
    output logic [NPORTS*DWIDTH-1:0] d_out,
    output logic [NPORTS-1:0]        valid_out
);

    localparam int unsigned BBITS = bank_bits(NBANKS);
    localparam int unsigned RBITS = row_bits(AWIDTH, NBANKS);
    localparam int unsigned DEPTH = 1 << RBITS;

    logic [BBITS-1:0]  bank_sel   [NPORTS];
    logic [RBITS-1:0]  row_sel    [NPORTS];
    logic [NPORTS-1:0] bank_req   [NBANKS];
    logic [NPORTS-1:0] bank_gnt   [NBANKS];
    logic [DWIDTH-1:0] bank_rdata [NBANKS];
    logic [NPORTS-1:0] rd_acc;

    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            bank_sel[p] = addr_in[p*AWIDTH +: BBITS];
            row_sel[p]  = addr_in[p*AWIDTH+BBITS +: RBITS];
        end
        for (int b = 0; b < NBANKS; b++) begin
            for (int p = 0; p < NPORTS; p++) begin
                bank_req[b][p] = en_in[p] && (bank_sel[p] == BBITS'(b));
            end
        end
    end

    // Each port targets one bank, so at most one arbiter can grant it.
    always_comb begin
        ready_out = '0;
        for (int b = 0; b < NBANKS; b++) begin
            ready_out = ready_out | bank_gnt[b];
        end
        if (rst_in) begin
            ready_out = '0;
        end
        rd_acc = ready_out & ~we_in;
    end

    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        logic [DWIDTH-1:0] mem [DEPTH];
        logic              acc_en;
        logic              acc_we;
        logic [RBITS-1:0]  acc_row;
        logic [DWIDTH-1:0] acc_wdata;

        rr_arbiter #(
            .N(NPORTS)
        ) u_arb (
            .clk_i(clk_in),
            .rst_i(rst_in),
            .req_i(bank_req[b]),
            .gnt_o(bank_gnt[b])
        );

        always_comb begin
            acc_en    = 1'b0;
            acc_we    = 1'b0;
            acc_row   = '0;
            acc_wdata = '0;
            for (int p = 0; p < NPORTS; p++) begin
                if (bank_gnt[b][p]) begin
                    acc_en    = 1'b1;
                    acc_we    = we_in[p];
                    acc_row   = row_sel[p];
                    acc_wdata = d_in[p*DWIDTH +: DWIDTH];
                end
            end
        end

        always_ff @(posedge clk_in) begin
            if (!rst_in && acc_en && acc_we) begin
                mem[acc_row] <= acc_wdata;
            end
        end

        assign bank_rdata[b] = mem[acc_row];
    end

    // Per-port stages: the array index is the port tag, so results stay on their port.
    rd_tag_t s1_q       [NPORTS];
    rd_tag_t out_stage  [NPORTS];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int p = 0; p < NPORTS; p++) begin
                s1_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NPORTS; p++) begin
                s1_q[p].valid <= rd_acc[p];
                if (rd_acc[p]) begin
                    s1_q[p].data <= MAX_DWIDTH'(bank_rdata[bank_sel[p]]);
                end
            end
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        rd_tag_t s2_q [NPORTS];

        always_ff @(posedge clk_in) begin
            if (rst_in) begin
                for (int p = 0; p < NPORTS; p++) begin
                    s2_q[p] <= '0;
                end
            end else begin
                for (int p = 0; p < NPORTS; p++) begin
                    s2_q[p].valid <= s1_q[p].valid;
                    if (s1_q[p].valid) begin
                        s2_q[p].data <= s1_q[p].data;
                    end
                end
            end
        end

        always_comb begin
            for (int p = 0; p < NPORTS; p++) begin
                out_stage[p] = s2_q[p];
            end
        end
    end else begin : g_lat1
        always_comb begin
            for (int p = 0; p < NPORTS; p++) begin
                out_stage[p] = s1_q[p];
            end
        end
    end

    logic unused_data;

    always_comb begin
        valid_out   = '0;
        d_out       = '0;
        unused_data = 1'b0;
        for (int p = 0; p < NPORTS; p++) begin
            valid_out[p]                = out_stage[p].valid;
            d_out[p*DWIDTH +: DWIDTH]   = out_stage[p].data[DWIDTH-1:0];
            unused_data                 = unused_data ^ (^out_stage[p].data);
        end
    end

endmodule

// File: tb/tb_mpram_banked.sv
// Directed bench: two instances (RD_LAT=1 and RD_LAT=2) share one stimulus stream.
module tb_mpram_banked;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 8;
    localparam int unsigned NP = 4;
    localparam int unsigned NB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [NP-1:0]        en;
    logic [NP-1:0]        we;
    logic [NP*AW-1:0]     addr;
    logic [NP*DW-1:0]     din;
    logic [NP-1:0]        rdy1, vld1, rdy2, vld2;
    logic [NP*DW-1:0]     q1, q2;

    int total = 0;
    int bad   = 0;

    mpram_banked #(
        .DWIDTH(DW), .AWIDTH(AW), .NPORTS(NP), .NBANKS(NB), .RD_LAT(1)
    ) dut1 (
        .clk_in(clk), .rst_in(rst), .en_in(en), .we_in(we), .addr_in(addr), .d_in(din),
        .ready_out(rdy1), .d_out(q1), .valid_out(vld1)
    );

    mpram_banked #(
        .DWIDTH(DW), .AWIDTH(AW), .NPORTS(NP), .NBANKS(NB), .RD_LAT(2)
    ) dut2 (
        .clk_in(clk), .rst_in(rst), .en_in(en), .we_in(we), .addr_in(addr), .d_in(din),
        .ready_out(rdy2), .d_out(q2), .valid_out(vld2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle();
        en = '0;
        we = '0;
    endtask

    task automatic set_port(input int p, input logic e, input logic w,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        en[p]            = e;
        we[p]            = w;
        addr[p*AW +: AW] = a;
        din[p*DW +: DW]  = d;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        en   = '1;
        we   = '0;
        addr = {8'h0C, 8'h08, 8'h04, 8'h00};
        din  = '0;
        step();
        step();
        settle();
        total++;
        if (rdy1 !== 4'b0000) begin
            bad++; $display("FAIL reset_ready got=%b want=0000", rdy1);
        end
        total++;
        if (vld1 !== 4'b0000 || vld2 !== 4'b0000) begin
            bad++; $display("FAIL reset_valid got=%b/%b want=0000", vld1, vld2);
        end
        total++;
        if (q1 !== '0 || q2 !== '0) begin
            bad++; $display("FAIL reset_dout got=%h/%h want=0", q1, q2);
        end
        step();
        rst = 1'b0;
        settle();
        total++;
        if (rdy1 !== 4'b0001) begin
            bad++; $display("FAIL post_reset_grant got=%b want=0001", rdy1);
        end
        idle();
        step();
    endtask

    task automatic test_write_read();
        set_port(0, 1'b1, 1'b1, 8'h05, 32'hDEADBEEF);
        settle();
        total++;
        if (rdy1 !== 4'b0001) begin
            bad++; $display("FAIL wr_ready got=%b want=0001", rdy1);
        end
        step();
        idle();
        set_port(1, 1'b1, 1'b0, 8'h05, 32'h0);
        settle();
        total++;
        if (rdy1 !== 4'b0010 || vld1 !== 4'b0000) begin
            bad++; $display("FAIL rd_ready got=%b/%b want=0010/0000", rdy1, vld1);
        end
        step();
        idle();
        settle();
        total++;
        if (vld1 !== 4'b0010 || q1[1*DW +: DW] !== 32'hDEADBEEF) begin
            bad++; $display("FAIL raw_data got=%b/%h want=0010/deadbeef", vld1, q1[1*DW +: DW]);
        end
        step();
        settle();
        total++;
        if (vld1 !== 4'b0000 || q1[1*DW +: DW] !== 32'hDEADBEEF) begin
            bad++; $display("FAIL hold_data got=%b/%h want=0000/deadbeef", vld1, q1[1*DW +: DW]);
        end
        step();
    endtask

    task automatic test_parallel();
        for (int p = 0; p < NP; p++) set_port(p, 1'b1, 1'b1, 8'(p), 32'hA0000000 | p);
        settle();
        total++;
        if (rdy1 !== 4'b1111) begin
            bad++; $display("FAIL par_wr_ready got=%b want=1111", rdy1);
        end
        step();
        idle();
        for (int p = 0; p < NP; p++) set_port(p, 1'b1, 1'b0, 8'(p), 32'h0);
        settle();
        total++;
        if (rdy1 !== 4'b1111) begin
            bad++; $display("FAIL par_rd_ready got=%b want=1111", rdy1);
        end
        step();
        idle();
        settle();
        total++;
        if (vld1 !== 4'b1111) begin
            bad++; $display("FAIL par_valid got=%b want=1111", vld1);
        end
        for (int p = 0; p < NP; p++) begin
            total++;
            if (q1[p*DW +: DW] !== (32'hA0000000 | p)) begin
                bad++; $display("FAIL par_data port=%0d got=%h want=%h", p, q1[p*DW +: DW],
                                32'hA0000000 | p);
            end
        end
        step();
    endtask

    task automatic test_round_robin();
        logic [AW-1:0] ra [NP];
        ra = '{8'h00, 8'h04, 8'h08, 8'h0C};
        for (int k = 0; k < NP; k++) begin
            set_port(0, 1'b1, 1'b1, ra[k], 32'hC0DE0000 | 32'(ra[k]));
            step();
        end
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int p = 0; p < NP; p++) set_port(p, 1'b1, 1'b0, ra[p], 32'h0);
        for (int k = 0; k < NP; k++) begin
            settle();
            total++;
            if (rdy1 !== 4'(1 << k)) begin
                bad++; $display("FAIL rr_grant step=%0d got=%b want=%b", k, rdy1, 4'(1 << k));
            end
            total++;
            if (vld1 !== ((k == 0) ? 4'b0000 : 4'(1 << (k - 1)))) begin
                bad++; $display("FAIL rr_valid step=%0d got=%b", k, vld1);
            end
            if (k > 0) begin
                total++;
                if (q1[(k-1)*DW +: DW] !== (32'hC0DE0000 | 32'(ra[k-1]))) begin
                    bad++; $display("FAIL rr_data port=%0d got=%h want=%h", k - 1,
                                    q1[(k-1)*DW +: DW], 32'hC0DE0000 | 32'(ra[k-1]));
                end
            end
            step();
            en[k] = 1'b0;
        end
        set_port(0, 1'b1, 1'b0, 8'h00, 32'h0);
        settle();
        total++;
        if (rdy1 !== 4'b0001 || vld1 !== 4'b1000) begin
            bad++; $display("FAIL rr_wrap got=%b/%b want=0001/1000", rdy1, vld1);
        end
        total++;
        if (q1[3*DW +: DW] !== 32'hC0DE000C) begin
            bad++; $display("FAIL rr_last_data got=%h want=c0de000c", q1[3*DW +: DW]);
        end
        step();
        idle();
        settle();
        total++;
        if (vld1 !== 4'b0001 || q1[0 +: DW] !== 32'hC0DE0000) begin
            bad++; $display("FAIL rr_renew got=%b/%h want=0001/c0de0000", vld1, q1[0 +: DW]);
        end
        step();
    endtask

    task automatic test_rd_lat2();
        set_port(2, 1'b1, 1'b1, 8'h7F, 32'h12345678);
        settle();
        total++;
        if (rdy2 !== 4'b0100) begin
            bad++; $display("FAIL lat2_wr_ready got=%b want=0100", rdy2);
        end
        step();
        idle();
        set_port(2, 1'b1, 1'b0, 8'h7F, 32'h0);
        settle();
        total++;
        if (rdy2 !== 4'b0100) begin
            bad++; $display("FAIL lat2_rd_ready got=%b want=0100", rdy2);
        end
        step();
        idle();
        settle();
        total++;
        if (vld2 !== 4'b0000) begin
            bad++; $display("FAIL lat2_early got=%b want=0000", vld2);
        end
        step();
        settle();
        total++;
        if (vld2 !== 4'b0100 || q2[2*DW +: DW] !== 32'h12345678) begin
            bad++; $display("FAIL lat2_data got=%b/%h want=0100/12345678", vld2, q2[2*DW +: DW]);
        end
        step();
        settle();
        total++;
        if (vld2 !== 4'b0000) begin
            bad++; $display("FAIL lat2_pulse got=%b want=0000", vld2);
        end
        step();
    endtask

    task automatic test_reset_flush();
        set_port(3, 1'b1, 1'b0, 8'h7F, 32'h0);
        settle();
        total++;
        if (rdy2 !== 4'b1000) begin
            bad++; $display("FAIL flush_accept got=%b want=1000", rdy2);
        end
        step();
        idle();
        rst = 1'b1;
        set_port(3, 1'b1, 1'b0, 8'h7F, 32'h0);
        settle();
        total++;
        if (rdy2 !== 4'b0000 || vld2 !== 4'b0000) begin
            bad++; $display("FAIL flush_hold got=%b/%b want=0000/0000", rdy2, vld2);
        end
        step();
        idle();
        settle();
        total++;
        if (vld2 !== 4'b0000 || q2 !== '0) begin
            bad++; $display("FAIL flush_drop got=%b/%h want=0000/0", vld2, q2);
        end
        step();
        rst = 1'b0;
        set_port(3, 1'b1, 1'b0, 8'h7F, 32'h0);
        settle();
        total++;
        if (vld2 !== 4'b0000 || rdy2 !== 4'b1000) begin
            bad++; $display("FAIL flush_after got=%b/%b want=0000/1000", vld2, rdy2);
        end
        step();
        idle();
        step();
        settle();
        total++;
        if (vld2 !== 4'b1000 || q2[3*DW +: DW] !== 32'h12345678) begin
            bad++; $display("FAIL flush_reread got=%b/%h want=1000/12345678", vld2,
                            q2[3*DW +: DW]);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_parallel();
        test_round_robin();
        test_rd_lat2();
        test_reset_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mpram_banked.md
Name: mpram_banked

Overview:
Parametrised multi-port banked RAM. It generalises the two-port RAM to NPORTS symmetric request ports on one clock. Storage is split into NBANKS low-order-interleaved single-port banks, with a round-robin arbiter per bank and a configurable read-latency pipeline. It is the shared storage core that the MultiPortCache input ports access.

Parameters:
DWIDTH, 32, data width per port
AWIDTH, 8, word address width; must exceed BBITS
NPORTS, 4, number of request ports (>=2)
NBANKS, 4, number of banks; power of two, >=2; BBITS = log2(NBANKS)
RD_LAT, 1, read latency in cycles from acceptance to valid_out; 1 or 2

Ports:
clk_in  in  1  clock; all logic is on the rising edge
rst_in  in  1  reset; synchronous, active-high
en_in  in  NPORTS  per-port request
we_in  in  NPORTS  per-port write (1) / read (0), qualified by en_in
addr_in  in  NPORTS*AWIDTH  per-port word address; port p occupies slice p
d_in  in  NPORTS*DWIDTH  per-port write data
ready_out  out  NPORTS  grant; request accepted on the edge where en_in[p] && ready_out[p]
d_out  out  NPORTS*DWIDTH  per-port read data
valid_out  out  NPORTS  one-cycle pulse marking d_out valid

Behaviour:
- Address map: bank = addr[BBITS-1:0]; row = addr[AWIDTH-1:BBITS]; each bank holds 2^(AWIDTH-BBITS) words.
- Each bank serves at most one access (read or write) per cycle.
- Arbitration, per bank:
  - requesters are the ports with en_in=1 whose address maps to that bank;
  - a round-robin arbiter grants exactly one of them;
  - ready_out[p] is combinational from en_in/addr_in and the bank pointer; ready_out[p]=0 whenever en_in[p]=0.
- RR pointer:
  - after a grant to port g, the bank pointer becomes (g+1) mod NPORTS, and the search starts at the pointer;
  - the pointer is unchanged in cycles with no grant for that bank.
- Independent banks: accesses to different banks in the same cycle all proceed in parallel.
- Stalled requester: keeps en_in/we_in/addr_in/d_in stable until granted. Retracting en_in before the grant is legal; that request is simply dropped.
- Write: memory is updated on the accepting edge. No valid_out is generated for writes.
- Read: the row is read on the accepting edge.
  - RD_LAT=1: d_out[p] and valid_out[p] are registered and appear on the next cycle.
  - RD_LAT=2: one additional output register stage.
  - valid_out[p] is high for exactly one cycle per accepted read.
  - d_out[p] holds its last value until the next read result for that port.
  - The pipeline carries the port tag, so results never cross ports.
- Read-after-write to the same address in consecutive accepted cycles returns the new data.
- A read and a write to the same address in the same cycle cannot occur, because they target the same bank and only one is granted.
- Throughput: one access per bank per cycle; the pipeline is fully pipelined with no bubbles.
- Reset (rst_in=1 on an edge), which has priority over any request:
  - valid_out=0, d_out=0, all RR pointers=0;
  - the read pipeline is flushed, so reads in flight are dropped and never produce valid_out;
  - memory contents are not reset;
  - ready_out is forced to 0 while rst_in=1.

Decomposition:
- Package mpram_pkg:
  - BBITS and row-width derivation functions;
  - port-index width constant;
  - typedef struct rd_tag_t {valid, data} for pipeline stages.
- Sub-module rr_arbiter (NPORTS-wide request vector, registered pointer, one-hot grant), instantiated once per bank in a generate loop.
- Bank storage is inferred inside mpram_banked as a generated array of single-port memories.

Test Plan (NPORTS=4, NBANKS=4, AWIDTH=8, DWIDTH=32):
1. Hold rst_in=1 for 2 cycles with en_in=4'hF -> ready_out=0, valid_out=0, d_out=0. First cycle after release: all four ports requesting bank 0 -> ready_out=4'b0001.
2. Port0 writes 0xDEADBEEF to 0x05; next cycle port1 reads 0x05 (RD_LAT=1) -> valid_out[1] pulses one cycle after acceptance with d_out[1]=0xDEADBEEF; d_out[1] holds afterwards.
3. Ports 0-3 read 0x00, 0x01, 0x02, 0x03 in the same cycle -> ready_out=4'hF; next cycle valid_out=4'hF with each port's own data.
4. Ports 0-3 all read bank 0 (0x00, 0x04, 0x08, 0x0C) and hold until granted -> grants 0,1,2,3 in consecutive cycles; valid_out[p] follows each grant by one cycle; a renewed port0 request after the last grant is granted next.
5. RD_LAT=2 build, port2 reads 0x7F after writing 0x12345678 -> valid_out[2] exactly two cycles after acceptance, data 0x12345678.
6. Port3 read accepted, rst_in=1 on the following edge -> valid_out stays 0. After reset, a re-read of the same address returns the pre-reset memory contents.
